// File: rtl/iir_out_fifo.sv
// Show-ahead output FIFO for the IIR filter: absorbs dOut samples without
// back-pressuring the filter, drops samples when full and records a sticky overflow.
module iir_out_fifo #(
  parameter int NB    = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vIn,
  input  logic [NB-1:0]            dIn,
  input  logic                     rdy,
  input  logic                     clr_ovf,
  output logic                     vOut,
  output logic [NB-1:0]            dOut,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NB-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic empty, full, pop, push, drop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // Pop decides first so a full FIFO can still accept the incoming sample.
  assign pop  = !empty && rdy;
  assign push = vIn && (!full || pop);
  assign drop = vIn && full && !pop;

  assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Overflow set has priority over the clear request.
  assign ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage has no reset; cnt_q gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dIn;
  end

  assign vOut = !empty;
  assign dOut = empty ? '0 : mem_q[rd_ptr_q];
  assign cnt  = cnt_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_iir_out_fifo.sv
// Scoreboard bench for iir_out_fifo: the bench model predicts writes/pops and
// queues expected samples, which are compared when the DUT presents them.
module tb_iir_out_fifo;

  localparam int NB    = 12;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vIn;
  logic [NB-1:0] dIn;
  logic          rdy;
  logic          clr_ovf;
  logic          vOut;
  logic [NB-1:0] dOut;
  logic [CW-1:0] cnt;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] exp_q [$];
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;

  iir_out_fifo #(.NB(NB), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vIn     (vIn),
    .dIn     (dIn),
    .rdy     (rdy),
    .clr_ovf (clr_ovf),
    .vOut    (vOut),
    .dOut    (dOut),
    .cnt     (cnt),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive inputs, predict write/pop, compare popped head,
  // advance past the edge and compare occupancy against the model.
  task automatic step(input logic v, input logic [NB-1:0] d, input logic r, input logic c);
    logic          do_pop, do_push;
    logic [NB-1:0] exp_d;
    vIn = v; dIn = d; rdy = r; clr_ovf = c;
    do_pop  = (m_cnt != 0) && r;
    do_push = v && ((m_cnt != DEPTH) || do_pop);
    if (do_pop) begin
      exp_d = exp_q.pop_front();
      checks++;
      if (dOut !== exp_d || vOut !== 1'b1) begin
        errors++;
        $display("FAIL pop_data: got dOut=%h vOut=%b, want dOut=%h vOut=1", dOut, vOut, exp_d);
      end
    end
    if (do_push) exp_q.push_back(d);
    if (v && !do_push) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_cnt = m_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    @(posedge clk); #1;
    checks++;
    if (cnt !== CW'(m_cnt) || ovf !== m_ovf) begin
      errors++;
      $display("FAIL occupancy: got cnt=%0d ovf=%b, want cnt=%0d ovf=%b", cnt, ovf, m_cnt, m_ovf);
    end
    vIn = 1'b0; rdy = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < DEPTH; i++) step(1'b1, NB'(base + i), 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && m_cnt != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_empty(input string tag);
    checks++;
    if (vOut !== 1'b0 || dOut !== '0 || cnt !== '0) begin
      errors++;
      $display("FAIL %s: got vOut=%b dOut=%h cnt=%0d, want vOut=0 dOut=0 cnt=0", tag, vOut, dOut, cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vIn = 1'b1; dIn = 12'h5A5; rdy = 1'b1; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_empty("reset_outputs");
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b, want 0", ovf);
    end
    vIn = 1'b0; rdy = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    fill(12'h001);
    checks++;
    if (cnt !== CW'(8) || ovf !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got cnt=%0d ovf=%b, want cnt=8 ovf=0", cnt, ovf);
    end
    drain();
    check_empty("drain_empty");
  endtask

  task automatic test_overflow();
    fill(12'h001);
    step(1'b1, 12'hABC, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1 || cnt !== CW'(8)) begin
      errors++;
      $display("FAIL overflow_set: got ovf=%b cnt=%0d, want ovf=1 cnt=8", ovf, cnt);
    end
    drain();
    check_empty("overflow_drain");
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got ovf=%b, want 0", ovf);
    end
  endtask

  task automatic test_full_simul();
    fill(12'h001);
    step(1'b1, 12'h7FF, 1'b1, 1'b0);
    checks++;
    if (cnt !== CW'(8) || ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_simul: got cnt=%0d ovf=%b, want cnt=8 ovf=0", cnt, ovf);
    end
    drain();
    check_empty("full_simul_drain");
  endtask

  task automatic test_no_bypass();
    step(1'b1, 12'h3C3, 1'b1, 1'b0);
    checks++;
    if (cnt !== CW'(1) || vOut !== 1'b1 || dOut !== 12'h3C3) begin
      errors++;
      $display("FAIL no_bypass: got cnt=%0d vOut=%b dOut=%h, want cnt=1 vOut=1 dOut=3c3", cnt, vOut, dOut);
    end
    drain();
  endtask

  task automatic test_wrap();
    int sent = 0;
    int max_cnt = 0;
    // Three writes out of every four cycles, pops on alternate cycles: the
    // queue builds up and both pointers wrap several times without overflow.
    for (int i = 0; i < 200 && sent < 20; i++) begin
      logic v;
      v = (i % 4) != 3;
      step(v, NB'(12'h800 + sent), logic'(i % 2 == 0), 1'b0);
      if (v) sent++;
      if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
    end
    drain();
    checks++;
    if (max_cnt > DEPTH || ovf !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap: got max_cnt=%0d ovf=%b left=%0d, want max_cnt<=8 ovf=0 left=0", max_cnt, ovf, exp_q.size());
    end
    check_empty("wrap_empty");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, NB'(12'h200 + i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_empty("reset_mid_async");
    exp_q.delete();
    m_cnt = 0; m_ovf = 1'b0;
    vIn = 1'b1; dIn = 12'hFFF; rdy = 1'b1;
    @(posedge clk); #1;
    check_empty("reset_ignores_inputs");
    vIn = 1'b0; rdy = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 12'h123, 1'b0, 1'b0);
    checks++;
    if (vOut !== 1'b1 || dOut !== 12'h123 || cnt !== CW'(1)) begin
      errors++;
      $display("FAIL reset_mid_head: got vOut=%b dOut=%h cnt=%0d, want vOut=1 dOut=123 cnt=1", vOut, dOut, cnt);
    end
    drain();
  endtask

  task automatic test_race();
    fill(12'h010);
    step(1'b1, 12'h111, 1'b0, 1'b0);
    step(1'b1, 12'h555, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b1 || cnt !== CW'(8)) begin
      errors++;
      $display("FAIL set_clear_race: got ovf=%b cnt=%0d, want ovf=1 cnt=8", ovf, cnt);
    end
    drain();
    step(1'b0, '0, 1'b0, 1'b1);
    check_empty("race_final");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_simul();
    test_no_bypass();
    test_wrap();
    test_reset_mid();
    test_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
